bcd_conv_arbiter: RTL and testbench
===================================

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of requesting channels (2..8).
REQ-002 SHALL have parameter CONV_TIMEOUT, default 64, giving the maximum cycles allowed from conv_start rise to conv_done1 high.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, NUM_CH bits: per-channel conversion request, level.
REQ-006 SHALL have port din_flat, input, 16*NUM_CH bits: per-channel unsigned binary operand; channel i occupies [16i+15:16i].
REQ-007 SHALL have port conv_start, output, 1 bit: start line to the shared binary-to-BCD converter.
REQ-008 SHALL have port conv_din, output, 16 bits: operand to the converter.
REQ-009 SHALL have port conv_done1, input, 1 bit: converter completion flag.
REQ-010 SHALL have port conv_out, input, 20 bits: converter 5-digit BCD result.
REQ-011 SHALL have port gnt, output, NUM_CH bits: one-hot grant; all zero when idle.
REQ-012 SHALL have port ack, output, NUM_CH bits: one-cycle pulse on the served channel when its result is stored.
REQ-013 SHALL have port bcd_flat, output, 20*NUM_CH bits: last stored BCD result per channel; channel i occupies [20i+19:20i].
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky flag, cleared only by rst.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPTURE and RELEASE.
REQ-017 In IDLE with any req bit high, the block SHALL grant the channel by round-robin: it scans from (last_served+1) mod NUM_CH upward, wraps, and selects the first set bit.
REQ-018 On grant, the block SHALL register gnt one-hot and latch conv_din from that channel's din_flat slice, then go to ISSUE the next cycle.
REQ-019 The block SHALL hold conv_din stable from grant until the FSM leaves RELEASE.
REQ-020 In ISSUE, conv_start SHALL be 1; the block SHALL go to CAPTURE on the first cycle conv_done1=1.
REQ-021 In CAPTURE (one cycle), the block SHALL store conv_out into the granted channel's bcd_flat slice, pulse ack for that channel, update last_served, drive conv_start=0, and go to RELEASE.
REQ-022 In RELEASE, conv_start SHALL be 0; the block SHALL go to IDLE on the first cycle conv_done1=0, and gnt SHALL clear on that transition.
REQ-023 Issue-to-done latency from the converter is about 17 cycles; the block SHALL NOT depend on an exact value.
REQ-024 Timeout: the block SHALL count cycles in ISSUE; if the count reaches CONV_TIMEOUT without conv_done1, it SHALL set timeout_err, leave bcd_flat unchanged, give no ack, update last_served, and go to RELEASE.
REQ-025 A requester SHALL drop req within one cycle of its ack; a req still high in the cycle after IDLE is re-entered counts as a new request.
REQ-026 A req falling while that channel is granted SHALL NOT abort the conversion; the result is stored and acked.
REQ-027 req and din changes on ungranted channels SHALL have no effect until they are granted.
REQ-028 Only one conversion SHALL be outstanding at a time, and the minimum spacing between two conv_start rises SHALL be 2 cycles after the RELEASE exit.

Reset
REQ-029 While rst is high, the block SHALL force: state=IDLE, conv_start=0, conv_din=0, gnt=0, ack=0, busy=0, timeout_err=0, all bcd_flat=0, last_served=NUM_CH-1 (so channel 0 has first priority), timeout counter=0.
REQ-030 rst asserted mid-conversion SHALL drop conv_start immediately.
REQ-031 After rst releases, the block SHALL wait in IDLE; if conv_done1 is high, the first grant SHALL wait until conv_done1=0 (IDLE treats conv_done1=1 as converter not ready).

Verification
REQ-032 Single request: req=0001, ch0 din=12345 -> gnt=0001, conv_din=0x3039, ack[0] pulse, bcd ch0=0x12345, busy low after conv_done1 falls.
REQ-033 Round robin: req=1111 held, each ch re-requesting after ack -> grant order 0,1,2,3,0; no channel served twice before all others.
REQ-034 Boundary values: ch2 din=0 -> bcd ch2=0x00000; ch3 din=65535 -> bcd ch3=0x65535.
REQ-035 Timeout: a converter model never raising conv_done1 -> timeout_err=1 after 64 ISSUE cycles, no ack, next pending channel is then served.
REQ-036 Reset mid-ISSUE: rst pulse 10 cycles into a conversion -> conv_start=0 asynchronously, all outputs at reset values, next grant goes to ch0.
REQ-037 Req drop while granted: req[1] falls during ISSUE -> ack[1] is still pulsed and bcd ch1 is updated.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter sharing one binary-to-BCD converter among NUM_CH channels,
// with per-channel result storage and a sticky converter timeout flag.
module bcd_conv_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [16*NUM_CH-1:0]     din_flat,
    output logic                     conv_start,
    output logic [15:0]              conv_din,
    input  logic                     conv_done1,
    input  logic [19:0]              conv_out,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        ack,
    output logic [20*NUM_CH-1:0]     bcd_flat,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int LW = $clog2(NUM_CH);
    localparam int CW = $clog2(CONV_TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RELEASE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LW-1:0]     last_q, last_d, sel_q, sel_d, pick;
    logic              found;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [15:0]       din_q, din_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [19:0]       bcd_q [NUM_CH];

    // first requester after the last served channel, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int j;
            j = int'(last_q) + k;
            if (j >= NUM_CH) j -= NUM_CH;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = LW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found && !conv_done1) begin
                state_d = ISSUE;
                sel_d   = pick;
                gnt_d   = NUM_CH'(1) << pick;
                din_d   = din_flat[16*pick +: 16];
                cnt_d   = '0;
            end
            ISSUE: if (conv_done1) begin
                state_d = CAPTURE;
            end else if (cnt_q == CW'(CONV_TIMEOUT - 1)) begin
                state_d = RELEASE;
                err_d   = 1'b1;
                last_d  = sel_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            CAPTURE: begin
                state_d = RELEASE;
                last_d  = sel_q;
            end
            default: if (!conv_done1) begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LW'(NUM_CH - 1);
            sel_q   <= '0;
            gnt_q   <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) bcd_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == CAPTURE) bcd_q[sel_q] <= conv_out;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_bcd
        assign bcd_flat[20*g +: 20] = bcd_q[g];
    end

    assign conv_start  = state_q == ISSUE;
    assign conv_din    = din_q;
    assign gnt         = gnt_q;
    assign ack         = state_q == CAPTURE ? gnt_q : '0;
    assign busy        = state_q != IDLE;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed bench with a behavioural 17-cycle converter model.
module tb_bcd_conv_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din_flat;
    logic        conv_start;
    logic [15:0] conv_din;
    logic        conv_done1;
    logic [19:0] conv_out;
    logic [3:0]  gnt, ack;
    logic [79:0] bcd_flat;
    logic        busy, timeout_err;

    logic        cv_done = 1'b0, force_done, cv_dead;
    logic [4:0]  cv_cnt = '0;
    int          total = 0, bad = 0;

    bcd_conv_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .din_flat(din_flat),
        .conv_start(conv_start), .conv_din(conv_din), .conv_done1(conv_done1),
        .conv_out(conv_out), .gnt(gnt), .ack(ack), .bcd_flat(bcd_flat),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input logic [15:0] b);
        logic [35:0] s;
        s = {20'd0, b};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 5; d++) if (s[16+4*d +: 4] >= 4'd5) s[16+4*d +: 4] += 4'd3;
            s = s << 1;
        end
        return s[35:16];
    endfunction

    // converter: done rises 17 cycles after start, falls once start drops
    assign conv_done1 = cv_done | force_done;
    always @(posedge clk) begin
        if (conv_start && !cv_dead) begin
            if (cv_cnt == 5'd16) begin
                cv_done  <= 1'b1;
                conv_out <= to_bcd(conv_din);
            end else cv_cnt <= cv_cnt + 1'b1;
        end else begin
            cv_done <= 1'b0;
            cv_cnt  <= '0;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_wait busy=%b exp=0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; din_flat = '0; force_done = 1'b0; cv_dead = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({conv_start, busy, timeout_err, gnt, ack} !== 11'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {conv_start, busy, timeout_err, gnt, ack});
        end
        total++;
        if (conv_din !== 16'd0) begin bad++; $display("FAIL reset_din got=%h exp=0000", conv_din); end
        total++;
        if (bcd_flat !== 80'd0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", bcd_flat); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        din_flat[15:0] = 16'd12345; req = 4'b0001;
        for (int i = 0; i < 50 && gnt == 0; i++) @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        total++;
        if (conv_din !== 16'h3039) begin bad++; $display("FAIL single_din got=%h exp=3039", conv_din); end
        total++;
        if (conv_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", conv_start); end
        for (int i = 0; i < 200 && ack == 0; i++) @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
        req = '0;
        @(negedge clk);
        total++;
        if (bcd_flat[19:0] !== 20'h12345) begin bad++; $display("FAIL single_bcd got=%h exp=12345", bcd_flat[19:0]); end
        total++;
        if (conv_din !== 16'h3039) begin bad++; $display("FAIL single_din_hold got=%h exp=3039", conv_din); end
        wait_idle();
        total++;
        if ({conv_done1, gnt} !== 5'd0) begin bad++; $display("FAIL single_release got=%b exp=0", {conv_done1, gnt}); end
    endtask

    task automatic test_boundary();
        din_flat[47:32] = 16'd0; din_flat[63:48] = 16'hFFFF;
        for (int c = 2; c < 4; c++) begin
            req = 4'b0001 << c;
            for (int i = 0; i < 250 && ack == 0; i++) @(negedge clk);
            total++;
            if (ack !== (4'b0001 << c)) begin bad++; $display("FAIL bound_ack%0d got=%b", c, ack); end
            req = '0;
            @(negedge clk);
            wait_idle();
        end
        total++;
        if (bcd_flat[59:40] !== 20'h00000) begin bad++; $display("FAIL bound_ch2 got=%h exp=00000", bcd_flat[59:40]); end
        total++;
        if (bcd_flat[79:60] !== 20'h65535) begin bad++; $display("FAIL bound_ch3 got=%h exp=65535", bcd_flat[79:60]); end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] a;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 250 && ack == 0; i++) @(negedge clk);
            a = ack;
            total++;
            if (a !== (4'b0001 << exp_order[k])) begin
                bad++; $display("FAIL rr_order%0d got=%b exp_ch=%0d", k, a, exp_order[k]);
            end
            req = req & ~a;
            @(negedge clk);
            if (k < 4) req = req | a;
        end
        req = '0;
        wait_idle();
    endtask

    task automatic test_req_drop();
        din_flat[31:16] = 16'd999; req = 4'b0010;
        for (int i = 0; i < 50 && gnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        req = '0;
        for (int i = 0; i < 250 && ack == 0; i++) @(negedge clk);
        total++;
        if (ack !== 4'b0010) begin bad++; $display("FAIL drop_ack got=%b exp=0010", ack); end
        @(negedge clk);
        total++;
        if (bcd_flat[39:20] !== 20'h00999) begin bad++; $display("FAIL drop_bcd got=%h exp=00999", bcd_flat[39:20]); end
        wait_idle();
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen = 1'b0;
        cv_dead = 1'b1; din_flat[47:32] = 16'd77; din_flat[63:48] = 16'd4321; req = 4'b1100;
        for (int i = 0; i < 50 && gnt == 0; i++) @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL to_gnt got=%b exp=0100", gnt); end
        while (conv_start && n < 200) begin
            n++;
            if (ack != 0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (n !== 64) begin bad++; $display("FAIL to_cycles got=%0d exp=64", n); end
        total++;
        if ({seen, timeout_err} !== 2'b01) begin bad++; $display("FAIL to_flag ack_seen,err=%b exp=01", {seen, timeout_err}); end
        cv_dead = 1'b0;
        for (int i = 0; i < 50 && gnt != 4'b0; i++) @(negedge clk);
        for (int i = 0; i < 50 && gnt == 4'b0; i++) @(negedge clk);
        total++;
        if (gnt !== 4'b1000) begin bad++; $display("FAIL to_next got=%b exp=1000", gnt); end
        req = 4'b1000;
        for (int i = 0; i < 250 && ack == 0; i++) @(negedge clk);
        req = '0;
        @(negedge clk);
        total++;
        if ({bcd_flat[79:60], bcd_flat[59:40]} !== 40'h04321_00000) begin
            bad++; $display("FAIL to_bcd got=%h exp=0432100000", {bcd_flat[79:60], bcd_flat[59:40]});
        end
        wait_idle();
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        din_flat[31:16] = 16'd5; req = 4'b0010;
        for (int i = 0; i < 50 && gnt == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({conv_start, busy, timeout_err, gnt, ack} !== 11'd0) begin
            bad++; $display("FAIL rmid_ctrl got=%b exp=0", {conv_start, busy, timeout_err, gnt, ack});
        end
        total++;
        if ({conv_din, bcd_flat} !== 96'd0) begin bad++; $display("FAIL rmid_data got=%h exp=0", {conv_din, bcd_flat}); end
        req = '0;
        @(negedge clk);
        rst = 1'b0; force_done = 1'b1; req = 4'b1111;
        repeat (5) @(negedge clk);
        total++;
        if ({busy, gnt} !== 5'd0) begin bad++; $display("FAIL rmid_notready got=%b exp=0", {busy, gnt}); end
        force_done = 1'b0;
        for (int i = 0; i < 50 && gnt == 0; i++) @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%b exp=0001", gnt); end
        for (int i = 0; i < 250 && ack == 0; i++) @(negedge clk);
        req = '0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_req_drop();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
